// File: rtl/mdu_pkg.sv
// Shared MDU encodings: MDop codes, default latencies, HIsel select, FSM states.
// MDU_MADD_EN widens the set of accepted ops to include madd/maddu/msub/msubu.
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic HISEL_HI = 1'b1;
    localparam logic HISEL_LO = 1'b0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    function automatic logic md_valid(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= MD_MULT) && (op <= MD_MSUBU);
`else
        return (op >= MD_MULT) && (op <= MD_MTLO);
`endif
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MDU_MADD_EN to enable the multiply-accumulate ops (madd/maddu/msub/msubu).
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [3:0]  MDop,
    input  logic        start,
    input  logic        HIsel,
    output logic        busy,
    output logic [31:0] MDout
);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] hi, lo;
    logic [63:0] pend;
    logic        pend_wr;
    logic [3:0]  pend_op;

    logic        acc;
    logic [63:0] prod_s, prod_u;
    logic [63:0] res;
    logic        res_wr;
    logic [31:0] ncyc;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_nz, du_nz;
    logic [31:0] sq, sr, q_s, r_s, uq, ur;

    assign acc = start && (state == ST_IDLE) && md_valid(MDop);

    assign prod_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
    assign prod_u = {32'b0, D1} * {32'b0, D2};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_neg = D1[31];
    assign b_neg = D2[31];
    assign a_mag = a_neg ? -D1 : D1;
    assign b_mag = b_neg ? -D2 : D2;
    assign b_nz  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign du_nz = (D2 == 32'd0) ? 32'd1 : D2;
    assign sq    = a_mag / b_nz;
    assign sr    = a_mag % b_nz;
    assign q_s   = (a_neg ^ b_neg) ? -sq : sq;
    assign r_s   = a_neg ? -sr : sr;
    assign uq    = D1 / du_nz;
    assign ur    = D1 % du_nz;

    always_comb begin
        res    = {hi, lo};
        res_wr = 1'b1;
        ncyc   = 32'(MULT_CYCLES);
        unique case (MDop)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                res    = {r_s, q_s};
                res_wr = (D2 != 32'd0);
                ncyc   = 32'(DIV_CYCLES);
            end
            MD_DIVU: begin
                res    = {ur, uq};
                res_wr = (D2 != 32'd0);
                ncyc   = 32'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
            MD_MSUB:  res = {hi, lo} - prod_s;
            MD_MSUBU: res = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            pend_op <= MD_NONE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (acc) begin
                        if (MDop == MD_MTHI) begin
                            hi <= D1;
                        end else if (MDop == MD_MTLO) begin
                            lo <= D1;
                        end else begin
                            state   <= ST_BUSY;
                            cnt     <= ncyc;
                            pend    <= res;
                            pend_wr <= res_wr;
                            pend_op <= MDop;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt <= 32'd1) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        pend_op <= MD_NONE;
                        if (pend_wr && (pend_op != MD_NONE)) begin
                            {hi, lo} <= pend;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_BUSY);
    assign MDout = (HIsel == HISEL_HI) ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a driver pushes expected HI/LO per op, a monitor
// checks busy window and commit against a longint arithmetic reference.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [31:0] D1, D2;
    logic [3:0]  MDop;
    logic        start;
    logic        HIsel;
    logic        busy;
    logic [31:0] MDout;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .D1(D1), .D2(D2), .MDop(MDop),
        .start(start), .HIsel(HIsel), .busy(busy), .MDout(MDout)
    );

    typedef struct {
        int          e;
        int          due;
        logic [31:0] oh, ol, nh, nl;
        logic [3:0]  op;
    } item_t;

    item_t q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [31:0] mon_hi, mon_lo;
    logic        mon_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got busy=%0b hi=%08h lo=%08h, want busy=%0b hi=%08h lo=%08h",
                     nm, cyc, act[64], act[63:32], act[31:0], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
    function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, acc64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        acc64 = {m_hi, m_lo};
        case (op)
            4'd1: begin acc64 = sa * sb; {m_hi, m_lo} = acc64; return MC; end
            4'd2: begin acc64 = ua * ub; {m_hi, m_lo} = acc64; return MC; end
            4'd3: begin
                if (b != 0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
                return DC;
            end
            4'd4: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                return DC;
            end
            4'd5: begin m_hi = a; return 0; end
            4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            4'd7:  begin acc64 = acc64 + longint'(sa * sb); {m_hi, m_lo} = acc64; return MC; end
            4'd8:  begin acc64 = acc64 + ua * ub; {m_hi, m_lo} = acc64; return MC; end
            4'd9:  begin acc64 = acc64 - longint'(sa * sb); {m_hi, m_lo} = acc64; return MC; end
            4'd10: begin acc64 = acc64 - ua * ub; {m_hi, m_lo} = acc64; return MC; end
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: reads both HI and LO each cycle and scores the head item.
    initial begin
        item_t it;
        HIsel = 1'b0;
        forever begin
            @(negedge clk);
            HIsel = 1'b1;
            #1 mon_hi = MDout;
            HIsel = 1'b0;
            #1 mon_lo = MDout;
            mon_busy = busy;
            if (!reset && q.size() != 0) begin
                it = q[0];
                if (cyc >= it.e && cyc < it.due) begin
                    chk($sformatf("hold_op%0d", it.op), {mon_busy, mon_hi, mon_lo},
                        {1'b1, it.oh, it.ol});
                end else if (cyc == it.due) begin
                    void'(q.pop_front());
                    chk($sformatf("commit_op%0d", it.op), {mon_busy, mon_hi, mon_lo},
                        {1'b0, it.nh, it.nl});
                end else if (cyc > it.due) begin
                    void'(q.pop_front());
                    chk($sformatf("late_op%0d", it.op), {mon_busy, mon_hi, mon_lo},
                        {1'b0, it.nh, it.nl});
                end
            end
        end
    end

    // Issue one op at the current negedge; during busy, drive distracting inputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit fixed_junk);
        item_t it;
        int    lat;
        it.oh = m_hi;
        it.ol = m_lo;
        lat   = model(op, a, b);
        it.nh = m_hi;
        it.nl = m_lo;
        it.e  = cyc + 1;
        it.due = cyc + 1 + lat;
        it.op = op;
        q.push_back(it);
        start = 1'b1;
        MDop  = op;
        D1    = a;
        D2    = b;
        forever begin
            @(negedge clk);
            if (cyc >= it.due) break;
            if (fixed_junk) begin
                start = 1'b1;
                MDop  = MD_MULTU;
                D1    = 32'hFFFFFFFF;
                D2    = 32'hFFFFFFFF;
            end else begin
                start = 1'($urandom_range(0, 1));
                MDop  = 4'($urandom_range(0, 15));
                D1    = rnd_val();
                D2    = rnd_val();
            end
        end
        start = 1'b0;
        MDop  = MD_NONE;
    endtask

    task automatic chk_regs(input string nm, input logic [31:0] h, input logic [31:0] l);
        #3;
        chk(nm, {mon_busy, mon_hi, mon_lo}, {1'b0, h, l});
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        MDop  = MD_NONE;
        D1    = 0;
        D2    = 0;
        @(negedge clk);
        #3 chk("reset_state", {mon_busy, mon_hi, mon_lo}, 65'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 0);
        chk_regs("mult_neg2x3", 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(MD_MULTU, 32'hFFFFFFFE, 32'd3, 0);
        chk_regs("multu_x3", 32'h00000002, 32'hFFFFFFFA);
        issue(MD_MTHI, 32'h1234, 32'd0, 0);
        chk_regs("mthi", 32'h00001234, 32'hFFFFFFFA);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 0);
        chk_regs("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(MD_DIVU, 32'd7, 32'd0, 0);
        chk_regs("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        chk_regs("div_ovf", 32'h00000000, 32'h80000000);
        issue(MD_MULT, 32'd2, 32'd3, 1);
        chk_regs("busy_block", 32'h00000000, 32'h00000006);
        issue(MD_MTHI, 32'd0, 32'd0, 0);
        issue(MD_MTLO, 32'hFFFFFFFF, 32'd0, 0);
        issue(MD_MADDU, 32'd1, 32'd1, 0);
`ifdef MDU_MADD_EN
        chk_regs("maddu_1x1", 32'h00000001, 32'h00000000);
`else
        chk_regs("maddu_off", 32'h00000000, 32'hFFFFFFFF);
`endif

        // Reset in the middle of a divide.
        start = 1'b1;
        MDop  = MD_DIV;
        D1    = 32'd100;
        D2    = 32'd7;
        @(negedge clk);
        start = 1'b0;
        MDop  = MD_NONE;
        @(negedge clk);
        #3 chk("busy_before_rst", {mon_busy, 64'd0}, {1'b1, 64'd0});
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_hi = 0;
        m_lo = 0;
        #3 chk("rst_mid_div", {mon_busy, mon_hi, mon_lo}, 65'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk_regs("rst_no_write", 32'd0, 32'd0);

        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 0);
        end

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d items outstanding, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
